// File: rtl/mdu_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_alu_if
// Description : Handshake / operand / result bundle between the EX stage
//               and the registered ALU with multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_alu_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [3:0]       Ctrl;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Out;
  logic [WIDTH-1:0] Hi;
  logic             Zero;
  logic             DivByZero;

  // The pipeline side issues operations.
  modport master (
    output Start, Ctrl, In1, In2,
    input  Busy, Done, Out, Hi, Zero, DivByZero
  );

  // The ALU executes them.
  modport slave (
    input  Start, Ctrl, In1, In2,
    output Busy, Done, Out, Hi, Zero, DivByZero
  );
endinterface
`default_nettype wire

// File: rtl/mdu_alu.sv
`default_nettype none
// ============================================================================
// Module      : mdu_alu
// Description : Registered MIPS EX-stage ALU. Single-cycle ops finish in one
//               clock; MULTU (shift-add) and DIVU (restoring) iterate one bit
//               per clock behind a Start/Busy/Done handshake.
//               Optional divider: define MDU_DIV_EN to build it; otherwise
//               opcode 11 behaves like the other illegal opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic        clk,
  input  logic        rst,
  mdu_alu_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [SHW:0] c_cnt_init = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] c_cnt_one  = (SHW+1)'(1);

  state_t               r_state;
  state_t               w_next;
  logic [SHW:0]         r_cnt;
  logic [2*WIDTH-1:0]   r_work;     // {upper, lower} iteration register
  logic [WIDTH-1:0]     r_mcand;    // multiplicand or divisor
  logic [WIDTH-1:0]     r_out;
  logic [WIDTH-1:0]     r_hi;
  logic                 r_zero;
  logic                 r_dbz;

  logic                 w_accept;
  logic                 w_multi;
  logic                 w_last;
  logic [WIDTH-1:0]     w_res_lo;
  logic [WIDTH-1:0]     w_res_hi;
  logic                 w_dbz;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mul;
  logic [2*WIDTH-1:0]   w_step;

  // Start is only honoured outside RUN; requests during an iteration are dropped.
  assign w_accept = bus.Start && (r_state != S_RUN);
  assign w_last   = (r_cnt == c_cnt_one);

  // Decide whether the requested op needs the iterative datapath.
  always_comb begin
    w_multi = (bus.Ctrl == 4'd10);
`ifdef MDU_DIV_EN
    if ((bus.Ctrl == 4'd11) && (bus.In2 != '0)) begin
      w_multi = 1'b1;
    end
`endif
  end

  // Single-cycle results, including the divide-by-zero shortcut.
  always_comb begin
    w_res_lo = '0;
    w_res_hi = '0;
    w_dbz    = 1'b0;
    case (bus.Ctrl)
      4'd0:  w_res_lo = bus.In1 + bus.In2;
      4'd1:  w_res_lo = bus.In1 - bus.In2;
      4'd2:  w_res_lo = bus.In1 & bus.In2;
      4'd3:  w_res_lo = bus.In1 | bus.In2;
      4'd4:  w_res_lo = ~(bus.In1 | bus.In2);
      4'd5:  w_res_lo = bus.In1 ^ bus.In2;
      4'd6:  w_res_lo = bus.In1 << bus.In2[SHW-1:0];
      4'd7:  w_res_lo = bus.In1 >> bus.In2[SHW-1:0];
      4'd8:  w_res_lo = {{(WIDTH-1){1'b0}}, ($signed(bus.In1) < $signed(bus.In2))};
      4'd9:  w_res_lo = {{(WIDTH-1){1'b0}}, (bus.In1 < bus.In2)};
`ifdef MDU_DIV_EN
      4'd11: begin
        if (bus.In2 == '0) begin
          w_res_lo = '1;
          w_res_hi = bus.In1;
          w_dbz    = 1'b1;
        end
      end
`endif
      default: begin
        w_res_lo = '0;
      end
    endcase
  end

  // One shift-add multiply step: conditionally add the multiplicand to the
  // upper half, then shift the whole {carry, upper, lower} right by one.
  always_comb begin
    w_sum = {1'b0, r_work[2*WIDTH-1:WIDTH]} + (r_work[0] ? {1'b0, r_mcand} : '0);
    w_mul = {w_sum, r_work[WIDTH-1:1]};
  end

`ifdef MDU_DIV_EN
  logic                 r_is_div;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_div;

  // One restoring-divide step on {remainder, quotient}. The borrow bit of the
  // trial subtraction doubles as the "does not fit" flag because the trial
  // remainder is always below twice the divisor.
  always_comb begin
    w_trial = r_work[2*WIDTH-1:WIDTH-1];
    w_diff  = w_trial - {1'b0, r_mcand};
    if (!w_diff[WIDTH]) begin
      w_div = {w_diff[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1};
    end else begin
      w_div = {r_work[2*WIDTH-2:0], 1'b0};
    end
    w_step = r_is_div ? w_div : w_mul;
  end

  // Remember which iterative op is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_div <= 1'b0;
    end else if (w_accept && w_multi) begin
      r_is_div <= (bus.Ctrl == 4'd11);
    end
  end
`else
  // Only the multiplier iterates in this build.
  always_comb begin
    w_step = w_mul;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          w_next = w_multi ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.Start) begin
          w_next = w_multi ? S_RUN : S_DONE;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: latch operands, iterate, and load visible results only on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_work  <= '0;
      r_mcand <= '0;
      r_out   <= '0;
      r_hi    <= '0;
      r_zero  <= 1'b1;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_dbz <= w_dbz;
      if (w_multi) begin
        r_cnt <= c_cnt_init;
        if (bus.Ctrl == 4'd10) begin
          r_work  <= {{WIDTH{1'b0}}, bus.In2};
          r_mcand <= bus.In1;
        end else begin
          r_work  <= {{WIDTH{1'b0}}, bus.In1};
          r_mcand <= bus.In2;
        end
      end else begin
        r_out  <= w_res_lo;
        r_hi   <= w_res_hi;
        r_zero <= (w_res_lo == '0);
      end
    end else if (r_state == S_RUN) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - c_cnt_one;
      if (w_last) begin
        r_out  <= w_step[WIDTH-1:0];
        r_hi   <= w_step[2*WIDTH-1:WIDTH];
        r_zero <= (w_step[WIDTH-1:0] == '0);
      end
    end
  end

  assign bus.Busy      = (r_state == S_RUN);
  assign bus.Done      = (r_state == S_DONE);
  assign bus.Out       = r_out;
  assign bus.Hi        = r_hi;
  assign bus.Zero      = r_zero;
  assign bus.DivByZero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mdu_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_alu
// Description : Directed, table-driven bench for mdu_alu (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_alu;

  localparam int WIDTH = 32;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic [31:0] hi;
    logic        zero;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs [14];

  mdu_alu_if #(.WIDTH(WIDTH)) bus ();

  mdu_alu #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.Ctrl  = ctrl;
    bus.In1   = a;
    bus.In2   = b;
    tick();
    bus.Start = 1'b0;
  endtask

  initial begin
    int bad;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.Start = 1'b0;
    bus.Ctrl  = 4'd0;
    bus.In1   = '0;
    bus.In2   = '0;

    vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1};
    vecs[1]  = '{4'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 32'h0, 1'b1};
    vecs[2]  = '{4'd1,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 32'h0, 1'b0};
    vecs[3]  = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0, 1'b0};
    vecs[4]  = '{4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 32'h0, 1'b0};
    vecs[5]  = '{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 32'h0, 1'b0};
    vecs[6]  = '{4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 1'b0};
    vecs[7]  = '{4'd6,  32'h0000_0001, 32'd35,        32'h0000_0008, 32'h0, 1'b0};
    vecs[8]  = '{4'd7,  32'h8000_0000, 32'd4,         32'h0800_0000, 32'h0, 1'b0};
    vecs[9]  = '{4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0, 1'b0};
    vecs[10] = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1};
    vecs[11] = '{4'd12, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1};
    vecs[12] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 1'b1};
    vecs[13] = '{4'd0,  32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 32'h0, 1'b0};

    // Reset held for two cycles.
    repeat (2) tick();
    chk("rst_out",  bus.Out, 0);
    chk("rst_hi",   bus.Hi, 0);
    chk("rst_zero", bus.Zero, 1);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_dbz",  bus.DivByZero, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_out",  bus.Out, 0);
    chk("idle_zero", bus.Zero, 1);
    chk("idle_done", bus.Done, 0);

    // Back-to-back single-cycle ops: Start held high through the table.
    bus.Start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      bus.Ctrl = vecs[i].ctrl;
      bus.In1  = vecs[i].a;
      bus.In2  = vecs[i].b;
      tick();
      chk($sformatf("vec%0d_done", i), bus.Done, 1);
      chk($sformatf("vec%0d_out", i),  bus.Out, vecs[i].out);
      chk($sformatf("vec%0d_hi", i),   bus.Hi, vecs[i].hi);
      chk($sformatf("vec%0d_zero", i), bus.Zero, vecs[i].zero);
    end
    bus.Start = 1'b0;
    tick();
    chk("post_table_done", bus.Done, 0);
    chk("post_table_hold", bus.Out, 32'h7);

    // multu with a Start pulse mid-RUN that must be ignored.
    issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bad = 0;
    for (int i = 1; i <= WIDTH; i++) begin
      if (bus.Busy !== 1'b1 || bus.Done !== 1'b0 || bus.Out !== 32'h7) bad++;
      if (i == 10) begin
        bus.Start = 1'b1;
        bus.Ctrl  = 4'd0;
        bus.In1   = 32'h1;
        bus.In2   = 32'h1;
      end
      tick();
      bus.Start = 1'b0;
    end
    chk("multu_busy_window", bad, 0);
    chk("multu_done", bus.Done, 1);
    chk("multu_busy_low", bus.Busy, 0);
    chk("multu_hi", bus.Hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.Out, 32'h0000_0001);
    chk("multu_zero", bus.Zero, 0);
    tick();
    chk("multu_done_pulse", bus.Done, 0);

`ifdef MDU_DIV_EN
    issue(4'd11, 32'd100, 32'd7);
    bad = 0;
    for (int i = 1; i <= WIDTH; i++) begin
      if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) bad++;
      tick();
    end
    chk("divu_busy_window", bad, 0);
    chk("divu_done", bus.Done, 1);
    chk("divu_quot", bus.Out, 32'd14);
    chk("divu_rem",  bus.Hi, 32'd2);
    chk("divu_dbz",  bus.DivByZero, 0);
    tick();

    issue(4'd11, 32'd5, 32'd0);
    chk("div0_done", bus.Done, 1);
    chk("div0_busy", bus.Busy, 0);
    chk("div0_out",  bus.Out, 32'hFFFF_FFFF);
    chk("div0_hi",   bus.Hi, 32'd5);
    chk("div0_dbz",  bus.DivByZero, 1);
    issue(4'd0, 32'd1, 32'd1);
    chk("div0_clear_dbz", bus.DivByZero, 0);
    chk("div0_clear_out", bus.Out, 32'd2);
`else
    issue(4'd11, 32'd100, 32'd7);
    chk("nodiv_done", bus.Done, 1);
    chk("nodiv_busy", bus.Busy, 0);
    chk("nodiv_out",  bus.Out, 0);
    chk("nodiv_hi",   bus.Hi, 0);
    chk("nodiv_zero", bus.Zero, 1);
    chk("nodiv_dbz",  bus.DivByZero, 0);
`endif
    tick();

    // Reset in the middle of a multiply aborts it.
    issue(4'd0, 32'd9, 32'd9);
    chk("pre_abort_out", bus.Out, 32'd18);
    tick();
    issue(4'd10, 32'd6, 32'd7);
    bad = 0;
    repeat (9) begin
      if (bus.Done !== 1'b0) bad++;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (40) begin
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) bad++;
      tick();
    end
    chk("abort_no_done", bad, 0);
    chk("abort_out",  bus.Out, 0);
    chk("abort_hi",   bus.Hi, 0);
    chk("abort_zero", bus.Zero, 1);
    issue(4'd0, 32'd3, 32'd4);
    chk("after_abort_done", bus.Done, 1);
    chk("after_abort_out",  bus.Out, 32'd7);
    chk("after_abort_zero", bus.Zero, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_alu.md
# mdu_alu

Parametrised, registered ALU with a multi-cycle multiply/divide unit for the MIPS datapath. It sits in the EX stage and replaces the purely combinational ALU wherever MULTU/DIVU/HI/LO support is needed. Single-cycle ops complete in one clock. Multiply and divide iterate one bit per clock behind a Start/Busy/Done handshake, and EX stalls on Busy.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  op request; accepted only when Busy=0.
- Ctrl  input  4  opcode, sampled with Start.
- In1  input  WIDTH  operand A, sampled with Start.
- In2  input  WIDTH  operand B, sampled with Start.
- Busy  output  1  high while a multi-cycle op iterates.
- Done  output  1  one-cycle pulse; results valid from this cycle.
- Out  output  WIDTH  result / product low half / quotient.
- Hi  output  WIDTH  product high half / remainder; 0 for single-cycle ops.
- Zero  output  1  (Out == 0), registered with Out.
- DivByZero  output  1  set with Done of a divide with In2=0; cleared at next accepted Start.

## Operation
- Opcodes:
  - 0 add In1+In2 (wraps mod 2^WIDTH).
  - 1 sub In1−In2 (beq uses Zero).
  - 2 and.
  - 3 or.
  - 4 nor.
  - 5 xor.
  - 6 sll In1<<In2[SHW-1:0].
  - 7 srl (logical).
  - 8 slt (signed, Out=1/0).
  - 9 sltu (unsigned).
  - 10 multu, multi-cycle.
  - 11 divu, multi-cycle.
  - 12–15: Out=0, Hi=0, single-cycle.
- FSM states IDLE, RUN, DONE:
  - IDLE/DONE + Start, single-cycle op → DONE with Out/Hi/Zero loaded.
  - IDLE/DONE + Start, opcode 10/11 → RUN; operands latched; iteration counter = WIDTH.
  - DONE, no Start → IDLE.
  - RUN: counter decrements once per clock; counter reaches 0 → DONE with results loaded.
- Multiply: unsigned shift-add over 2·WIDTH bits; {Hi,Out} = In1·In2.
- Divide: unsigned restoring; Out=quotient, Hi=remainder.
  - In2=0: no RUN; goes straight to DONE with Out=all ones, Hi=In1, DivByZero=1.
- Out/Hi/Zero hold their values until the next Done; intermediate iteration state is never visible on them.
- Start while Busy=1 is ignored. No queueing.
- Reset values: Out=0, Hi=0, Zero=1, Busy=0, Done=0, DivByZero=0, state IDLE.
- rst during RUN aborts the op: no Done, outputs take reset values.

## Timing
- Start accepted at edge k:
  - single-cycle op: Done high in cycle k+1.
  - multu/divu: Busy high cycles k+1..k+WIDTH; Done high in cycle k+WIDTH+1 (Busy low).
- Divide-by-zero: Done in cycle k+1, same as single-cycle ops.
- Back-to-back: Start asserted in a Done cycle is accepted (DONE→DONE or DONE→RUN), so throughput is one single-cycle op per clock.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- MDU_DIV_EN:
  - defined: divider built; opcode 11 behaves as above.
  - undefined: no divider logic; opcode 11 is treated as illegal (single-cycle, Out=0, Hi=0, Zero=1, DivByZero=0). Multiply is unaffected.

## Test plan
- Reset: rst high 2 cycles → Out=0, Hi=0, Zero=1, Busy=0, Done=0; rst low with Start=0 → outputs unchanged.
- Single-cycle ops (WIDTH=32):
  - add 0xFFFFFFFF+1 → Out=0, Zero=1, Done at k+1.
  - slt 0xFFFFFFFF,1 → Out=1; sltu same operands → Out=0.
  - sll 1,35 → Out=8.
- multu 0xFFFFFFFF×0xFFFFFFFF → Busy k+1..k+32; Done k+33; Hi=0xFFFFFFFE, Out=0x00000001; Start pulsed mid-RUN is ignored.
- divu (MDU_DIV_EN):
  - 100/7 → Out=14, Hi=2, Done k+33.
  - 5/0 → Done k+1, Out=0xFFFFFFFF, Hi=5, DivByZero=1; next add clears DivByZero.
- rst at k+10 of a multu → no Done ever pulses; outputs at reset values; a following add 3+4 → Out=7 at k+1.
- Back-to-back adds on consecutive cycles → Done held high, Out updates every cycle. Build without MDU_DIV_EN → divu 100/7 gives Out=0, Zero=1, Done at k+1.
